hilo_muldiv: RTL and testbench



---
 rtl/hilo_muldiv.sv | 174 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: iterative shift-add multiply and
// restoring divide, one step per cycle, with direct HI/LO writes.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CMAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               div0;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   mag;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   lq;
    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]   lq_nx;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     tr;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign sgn   = op[0];
    assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == '0) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // acc holds the high product half or the partial remainder
    always_comb begin
        sum  = {1'b0, acc} + (lq[0] ? {1'b0, mag} : '0);
        tr   = {acc, lq[WIDTH-1]};
        diff = tr - {1'b0, mag};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_nx = diff[WIDTH-1:0];
                lq_nx  = {lq[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = tr[WIDTH-1:0];
                lq_nx  = {lq[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx = sum[WIDTH:1];
            lq_nx  = {sum[0], lq[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = {acc_nx, lq_nx};
        if (neg_q) prod = -prod;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                res_lo = '1;
                res_hi = a_q;
            end else begin
                res_lo = neg_q ? -lq_nx : lq_nx;
                res_hi = neg_r ? -acc_nx : acc_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_q    <= '0;
            mag    <= '0;
            acc    <= '0;
            lq     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= CMAX;
                        is_div <= op[1];
                        div0   <= (b == '0);
                        neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= sgn && a[WIDTH-1];
                        a_q    <= a;
                        mag    <= b_mag;
                        acc    <= '0;
                        lq     <= a_mag;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    lq  <= lq_nx;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // the final step's result lands on the RUN->FIN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (state == RUN) begin
            if (cnt == '0) begin
                hi_out <= res_hi;
                lo_out <= res_lo;
            end
        end else begin
            if (hi_wr) hi_out <= hi_in;
            if (lo_wr) lo_out <= lo_in;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: arithmetic reference model with per-cycle
// compare, literal result checks, reset abort and start-hold cases.
module tb_hilo_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_wr = 1'b0;
    logic         lo_wr = 1'b0;
    logic [W-1:0] hi_in = '0;
    logic [W-1:0] lo_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int checks = 0;
    int errors = 0;

    int           m_run = 0;
    bit           m_fin = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [2*W-1:0] m_res = '0;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_wr  (hi_wr),
        .lo_wr  (lo_wr),
        .hi_in  (hi_in),
        .lo_in  (lo_in),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    // returns {hi, lo}
    function automatic logic [2*W-1:0] ref_result(input logic [1:0] o,
                                                  input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
        longint sx, sy, q, rm;
        logic [2*W-1:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0;
        case (o)
            2'b00: r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            2'b01: r = sx * sy;
            2'b10: begin
                if (y == '0) r = {x, {W{1'b1}}};
                else r = {x % y, x / y};
            end
            default: begin
                if (y == '0) begin
                    r = {x, {W{1'b1}}};
                end else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[W-1:0], q[W-1:0]};
                end
            end
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0;
            m_fin = 1'b0;
            m_hi  = '0;
            m_lo  = '0;
        end else if (m_run > 0) begin
            m_run = m_run - 1;
            if (m_run == 0) begin
                {m_hi, m_lo} = m_res;
                m_fin = 1'b1;
            end
        end else begin
            if (hi_wr) m_hi = hi_in;
            if (lo_wr) m_lo = lo_in;
            if (m_fin) begin
                m_fin = 1'b0;
            end else if (start) begin
                m_res = ref_result(op, a, b);
                m_run = W;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_run > 0));
        chk("done", 64'(done), 64'(m_fin));
        chk("hi_out", 64'(hi_out), 64'(m_hi));
        chk("lo_out", 64'(lo_out), 64'(m_lo));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (m_run == 0 && !m_fin) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: model still busy after 100 cycles");
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        wait_idle();
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int nbusy);
        bit got;
        got = 1'b0;
        nbusy = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done, expected one within 60 cycles");
        end
    endtask

    task automatic lit(input string nm, input logic [1:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int nb;
        issue(o, x, y);
        wait_done(nb);
        chk({nm, "_hi"}, 64'(hi_out), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo_out), 64'(elo));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = '0;
            1: v = '1;
            2: v = 32'h8000_0000;
            3: v = 32'h0000_0001;
            4: v = 32'h7fff_ffff;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, dp, acc_cnt, done_cnt;
        bit prev;

        rst_n = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi", 64'(hi_out), 64'(0));
        chk("rst_lo", 64'(lo_out), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        issue(2'b00, 32'hffff_ffff, 32'hffff_ffff);
        wait_done(nb);
        chk("multu_busy_len", 64'(nb), 64'(32));
        chk("multu_hi", 64'(hi_out), 64'(32'hffff_fffe));
        chk("multu_lo", 64'(lo_out), 64'(32'h0000_0001));

        lit("mult", 2'b01, 32'hffff_fffd, 32'd5, 32'hffff_ffff, 32'hffff_fff1);
        lit("div_neg", 2'b11, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd);
        lit("divu_z", 2'b10, 32'h64, 32'd0, 32'h0000_0064, 32'hffff_ffff);
        lit("div_ovf", 2'b11, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000);
        lit("div_negb", 2'b11, 32'd7, 32'hffff_fffe, 32'h1, 32'hffff_fffd);
        lit("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        lit("div_z", 2'b11, 32'hffff_fff9, 32'd0, 32'hffff_fff9, 32'hffff_ffff);

        issue(2'b00, 32'd3, 32'd4);
        repeat (5) tick();
        hi_wr = 1'b1;
        hi_in = 32'h1234_5678;
        repeat (10) tick();
        hi_wr = 1'b0;
        wait_done(nb);
        chk("run_wr_hi", 64'(hi_out), 64'(0));
        chk("run_wr_lo", 64'(lo_out), 64'(12));
        tick();
        hi_wr = 1'b1;
        tick();
        hi_wr = 1'b0;
        #3;
        chk("idle_wr_hi", 64'(hi_out), 64'(32'h1234_5678));
        chk("idle_wr_lo", 64'(lo_out), 64'(12));

        issue(2'b01, $urandom, $urandom);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_hi", 64'(hi_out), 64'(0));
        chk("abort_lo", 64'(lo_out), 64'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        dp = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dp++;
        end
        chk("abort_no_done", 64'(dp), 64'(0));
        lit("after_abort", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42);

        wait_idle();
        op = 2'($urandom);
        a = pick();
        b = pick();
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        hi_in = $urandom;
        lo_in = $urandom;
        start = 1'b1;
        acc_cnt = 0;
        done_cnt = 0;
        prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && !prev) acc_cnt++;
            if (done) done_cnt++;
            prev = busy;
        end
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        chk("hold_accepts", 64'(acc_cnt), 64'(2));
        chk("hold_dones", 64'(done_cnt), 64'(1));

        repeat (1500) begin
            tick();
            start = ($urandom_range(0, 15) == 0);
            op    = 2'($urandom);
            a     = pick();
            b     = pick();
            hi_wr = ($urandom_range(0, 7) == 0);
            lo_wr = ($urandom_range(0, 7) == 0);
            hi_in = $urandom;
            lo_in = $urandom;
        end
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wait_idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
